// File: rtl/instram_loader.sv
// instram_loader: streams an instruction image, one byte per transfer, into an
// instruction RAM starting at a programmable base address. The CPU is held in
// reset while a load is in progress and is released when the load completes.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   load request (honoured only when idle or done)
//   base_adr, length        first RAM address and byte count, sampled on start
//   byte_data, byte_valid   incoming image byte stream
//   byte_ready              loader accepts a byte this cycle
//   ram_adr_w, ram_rwn,     RAM write port; ram_data leads its strobe by one
//   ram_cs, ram_data        cycle
//   busy, done, error       load status (done/error sticky until next start)
//   cpu_reset_n             CPU reset, low while held
//   checksum                sum mod 256 of all accepted bytes
module instram_loader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] base_adr,
    input  logic [15:0] length,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] ram_adr_w,
    output logic        ram_rwn,
    output logic        ram_cs,
    output logic [7:0]  ram_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_reset_n,
    output logic [7:0]  checksum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [15:0] base_q;
    logic [15:0] len_q;
    logic [15:0] count;      // bytes accepted so far in this load
    logic        stage_vld;  // byte accepted last edge; its data is on ram_data
    logic [15:0] stage_idx;  // index of that byte within the image
    logic        cs_q;
    logic [15:0] adr_q;
    logic [7:0]  data_q;
    logic        done_q;
    logic        error_q;
    logic        cpu_q;
    logic [7:0]  sum_q;

    logic        can_start;
    logic        over_range;
    logic [16:0] range_end;
    logic        xfer;
    logic        last_byte;

    always_comb begin
        can_start  = start && ((state == S_IDLE) || (state == S_DONE));
        range_end  = {1'b0, base_adr} + {1'b0, length};
        over_range = range_end > 17'd32768;
        byte_ready = (state == S_LOAD) && (count < len_q);
        xfer       = byte_valid && byte_ready;
        // count < len_q whenever xfer is set, so count + 1 cannot wrap
        last_byte  = xfer && ((count + 16'd1) == len_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            base_q    <= 16'd0;
            len_q     <= 16'd0;
            count     <= 16'd0;
            stage_vld <= 1'b0;
            stage_idx <= 16'd0;
            cs_q      <= 1'b0;
            adr_q     <= 16'd0;
            data_q    <= 8'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_q     <= 1'b0;
            sum_q     <= 8'd0;
        end else begin
            // Two-stage write pipeline: data register, then strobe + address.
            stage_vld <= xfer;
            if (xfer) begin
                stage_idx <= count;
                data_q    <= byte_data;
                sum_q     <= sum_q + byte_data;
                count     <= count + 16'd1;
            end
            cs_q <= stage_vld;
            if (stage_vld) begin
                adr_q <= base_q + stage_idx;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (can_start) begin
                        sum_q   <= 8'd0;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        cpu_q   <= 1'b0;
                        if (over_range) begin
                            error_q <= 1'b1;
                            state   <= S_DONE;
                        end else if (length == 16'd0) begin
                            done_q <= 1'b1;
                            cpu_q  <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            base_q <= base_adr;
                            len_q  <= length;
                            count  <= 16'd0;
                            state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (last_byte) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Last strobe is on the bus and nothing is left behind it.
                    if (cs_q && !stage_vld) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        cpu_q  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ram_cs      = cs_q;
    assign ram_rwn     = ~cs_q;
    assign ram_adr_w   = adr_q;
    assign ram_data    = data_q;
    assign busy        = (state == S_LOAD) || (state == S_FLUSH);
    assign done        = done_q;
    assign error       = error_q;
    assign cpu_reset_n = cpu_q;
    assign checksum    = sum_q;

endmodule

// File: tb/tb_instram_loader.sv
// Bench for instram_loader: a cycle-indexed scoreboard predicts every output
// after each clock edge, and directed tests pin the results with literals.
module tb_instram_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_adr = 16'd0;
    logic [15:0] length = 16'd0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [15:0] ram_adr_w;
    logic        ram_rwn;
    logic        ram_cs;
    logic [7:0]  ram_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_reset_n;
    logic [7:0]  checksum;

    instram_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .base_adr    (base_adr),
        .length      (length),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .ram_adr_w   (ram_adr_w),
        .ram_rwn     (ram_rwn),
        .ram_cs      (ram_cs),
        .ram_data    (ram_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cpu_reset_n (cpu_reset_n),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: phase 0 idle, 1 loading, 2 finished. strobe_at maps an edge
    // number to the address whose strobe must be visible after that edge.
    int          cyc = 0;
    int          phase = 0;
    int          done_at = -1;
    logic [15:0] m_base = 16'd0;
    logic [15:0] m_len = 16'd0;
    logic [15:0] m_cnt = 16'd0;
    logic [7:0]  m_sum = 8'd0;
    logic [7:0]  m_data = 8'd0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic        m_cpu = 1'b0;
    logic [15:0] strobe_at[int];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase = 0;
            done_at = -1;
            m_cnt = 16'd0;
            m_sum = 8'd0;
            m_data = 8'd0;
            m_done = 1'b0;
            m_err = 1'b0;
            m_cpu = 1'b0;
            strobe_at.delete();
        end else begin
            cyc++;
            if (phase == 1) begin
                if (m_cnt < m_len && byte_valid) begin
                    m_data = byte_data;
                    strobe_at[cyc + 1] = m_base + m_cnt;
                    m_sum = m_sum + byte_data;
                    m_cnt++;
                    if (m_cnt == m_len) done_at = cyc + 2;
                end else if (cyc == done_at) begin
                    phase = 2;
                    m_done = 1'b1;
                    m_cpu = 1'b1;
                end
            end else if (start) begin
                m_sum = 8'd0;
                m_done = 1'b0;
                m_err = 1'b0;
                m_cpu = 1'b0;
                if (int'(base_adr) + int'(length) > 32768) begin
                    phase = 2;
                    m_err = 1'b1;
                end else if (length == 16'd0) begin
                    phase = 2;
                    m_done = 1'b1;
                    m_cpu = 1'b1;
                end else begin
                    phase = 1;
                    m_base = base_adr;
                    m_len = length;
                    m_cnt = 16'd0;
                    done_at = -1;
                end
            end
        end
    end

    // Strobe log for the directed literal checks.
    logic [15:0] log_adr[$];
    logic [7:0]  log_data[$];
    int          log_cyc[$];
    logic [7:0]  prev_data = 8'd0;
    int          nedge = 0;

    always @(negedge clk) begin
        logic exp_cs;
        exp_cs = strobe_at.exists(cyc);
        check("byte_ready", byte_ready, phase == 1 && m_cnt < m_len);
        check("ram_cs", ram_cs, exp_cs);
        check("ram_rwn", ram_rwn, !exp_cs);
        if (exp_cs) check("ram_adr_w", ram_adr_w, strobe_at[cyc]);
        check("ram_data", ram_data, m_data);
        check("busy", busy, phase == 1);
        check("done", done, m_done);
        check("error", error, m_err);
        check("cpu_reset_n", cpu_reset_n, m_cpu);
        check("checksum", checksum, m_sum);
        if (ram_cs === 1'b1) begin
            log_adr.push_back(ram_adr_w);
            log_data.push_back(prev_data);
            log_cyc.push_back(nedge);
        end
        prev_data = ram_data;
        nedge++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] l);
        start = 1'b1;
        base_adr = b;
        length = l;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic v);
        byte_data = d;
        byte_valid = v;
        step();
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check("wait_done", done, 1'b1);
    endtask

    task automatic clear_log();
        log_adr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic check_strobes(input string name, input int n, input logic [15:0] base,
                                 input logic [31:0] data_packed, input bit consecutive);
        check({name, "_count"}, log_adr.size(), n);
        if (log_adr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check({name, "_adr"}, log_adr[i], base + 16'(i));
                check({name, "_data"}, log_data[i], data_packed[8*i +: 8]);
                if (consecutive) check({name, "_cyc"}, log_cyc[i], log_cyc[0] + i);
            end
        end
    endtask

    initial begin
        step();
        step();
        reset_n = 1'b1;
        step();

        // Test 1: back-to-back stream
        clear_log();
        do_start(16'h0100, 16'd4);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        send(8'h44, 1'b1);
        byte_valid = 1'b0;
        wait_done(10);
        check_strobes("t1", 4, 16'h0100, 32'h44332211, 1'b1);
        check("t1_checksum", checksum, 8'hAA);
        check("t1_cpu", cpu_reset_n, 1'b1);
        check("t1_busy", busy, 1'b0);

        // Test 2: range error, then an exact-fit load
        clear_log();
        do_start(16'h7FFF, 16'd2);
        check("t2_error", error, 1'b1);
        check("t2_cpu", cpu_reset_n, 1'b0);
        check("t2_done", done, 1'b0);
        step();
        step();
        step();
        check("t2_no_strobe", log_adr.size(), 0);
        do_start(16'h7FFE, 16'd2);
        check("t2_err_clr", error, 1'b0);
        send(8'hAB, 1'b1);
        send(8'hCD, 1'b1);
        byte_valid = 1'b0;
        wait_done(10);
        check_strobes("t2", 2, 16'h7FFE, 32'h0000CDAB, 1'b1);

        // Test 3: zero length
        clear_log();
        do_start(16'h1234, 16'd0);
        check("t3_done", done, 1'b1);
        check("t3_cpu", cpu_reset_n, 1'b1);
        step();
        step();
        step();
        check("t3_no_strobe", log_adr.size(), 0);

        // Test 4: gapped stream 1-0-0-1-1
        clear_log();
        do_start(16'h0000, 16'd3);
        send(8'hA1, 1'b1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'hA2, 1'b1);
        send(8'hA3, 1'b1);
        byte_valid = 1'b0;
        wait_done(10);
        check_strobes("t4", 3, 16'h0000, 32'h00A3A2A1, 1'b0);
        check("t4_checksum", checksum, 8'hE6);

        // Test 5: reset mid-load
        clear_log();
        do_start(16'h0200, 16'd5);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        byte_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t5_ready", byte_ready, 1'b0);
        check("t5_cs", ram_cs, 1'b0);
        check("t5_rwn", ram_rwn, 1'b1);
        check("t5_adr", ram_adr_w, 16'h0000);
        check("t5_data", ram_data, 8'h00);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_error", error, 1'b0);
        check("t5_cpu", cpu_reset_n, 1'b0);
        check("t5_checksum", checksum, 8'h00);
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        check("t5_no_strobe", log_adr.size(), 0);
        do_start(16'h0300, 16'd2);
        send(8'h5A, 1'b1);
        send(8'hA5, 1'b1);
        byte_valid = 1'b0;
        wait_done(10);
        check_strobes("t5", 2, 16'h0300, 32'h0000A55A, 1'b1);
        check("t5_reload_sum", checksum, 8'hFF);

        // Test 6: start during LOAD is ignored
        clear_log();
        do_start(16'h0400, 16'd3);
        send(8'h01, 1'b1);
        start = 1'b1;
        base_adr = 16'h0500;
        length = 16'd7;
        send(8'h02, 1'b1);
        start = 1'b0;
        send(8'h03, 1'b1);
        byte_valid = 1'b0;
        wait_done(10);
        check_strobes("t6", 3, 16'h0400, 32'h00030201, 1'b1);
        check("t6_checksum", checksum, 8'h06);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instram_loader.md
INSTRAM_LOADER -- requirements
Module: instram_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  single-cycle load request, sampled only in IDLE or DONE.
REQ-005 Port: base_adr  input  16  first RAM address, sampled on accepted start.
REQ-006 Port: length  input  16  byte count, sampled on accepted start.
REQ-007 Port: byte_data  input  8  incoming image byte.
REQ-008 Port: byte_valid  input  1  byte_data valid.
REQ-009 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port: ram_adr_w  output  16  instruction-RAM write address.
REQ-011 Port: ram_rwn  output  1  write strobe, 0 = write.
REQ-012 Port: ram_cs  output  1  RAM select.
REQ-013 Port: ram_data  output  8  RAM write data, presented one cycle ahead of its strobe.
REQ-014 Port: busy  output  1  load in progress.
REQ-015 Port: done  output  1  load complete; sticky until the next accepted start.
REQ-016 Port: error  output  1  range violation; sticky until the next accepted start.
REQ-017 Port: cpu_reset_n  output  1  CPU held in reset while low.
REQ-018 Port: checksum  output  8  sum mod 256 of all bytes written.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, FLUSH and DONE; DONE also covers error completion.
REQ-020 An accepted start with base_adr + length > 32768 (17-bit sum) SHALL go to DONE with error=1 on the next cycle, with no writes and cpu_reset_n kept low.
REQ-021 An accepted start with length = 0 and in range SHALL go to DONE with done=1 and cpu_reset_n=1 on the next cycle, with no writes.
REQ-022 Any other accepted start SHALL perform these actions and enter LOAD:
  - clear checksum, done and error;
  - latch base_adr and length;
  - set busy=1.
REQ-023 In LOAD, byte_ready SHALL be 1 while accepted < length; a transfer occurs on any edge where byte_valid and byte_ready are both 1.
REQ-024 A byte accepted at edge E0 SHALL follow this pipeline:
  - ram_data = byte during the cycle after E0;
  - ram_cs=1, ram_rwn=0 and ram_adr_w = base + index during the cycle after E1;
  - the RAM writes the byte at E2.
REQ-025 Back-to-back bytes SHALL sustain one write per cycle, with exactly one strobe cycle per byte.
REQ-026 When no strobe is due, outputs SHALL be ram_cs=0 and ram_rwn=1; ram_data SHALL hold its last value.
REQ-027 The checksum SHALL add each byte at its acceptance edge, modulo 256.
REQ-028 After the last byte is accepted, the FSM SHALL enter FLUSH, and byte_ready SHALL be 0 in FLUSH.
REQ-029 The FSM SHALL leave FLUSH for DONE on the edge that completes the last strobe cycle; done=1, busy=0 and cpu_reset_n=1 SHALL all appear in the following cycle.
REQ-030 A start while busy=1 SHALL be ignored.
REQ-031 A start in DONE SHALL be handled as in IDLE, and cpu_reset_n SHALL return to 0 for the new load.
REQ-032 Stalls (byte_valid=0) SHALL insert idle cycles between strobes without corrupting the address order.

Reset
REQ-033 While reset_n=0, and immediately on its assertion including mid-load, outputs SHALL be:
  - state = IDLE;
  - byte_ready=0, ram_cs=0, ram_rwn=1;
  - ram_adr_w=0, ram_data=0;
  - busy=0, done=0, error=0;
  - cpu_reset_n=0, checksum=0.
REQ-034 A reset mid-load SHALL drop any pending strobe, so that no write occurs after reset assertion.

Verification
REQ-035 Test 1: base=0x0100, length=4, bytes 11,22,33,44 streamed back-to-back -> strobes on four consecutive cycles at 0x0100..0x0103 with the matching data one cycle earlier; then checksum=0xAA, done=1, cpu_reset_n=1.
REQ-036 Test 2: base=0x7FFF, length=2 -> error=1 next cycle, zero strobes, cpu_reset_n=0; then base=0x7FFE, length=2 -> accepted, writes at 0x7FFE and 0x7FFF.
REQ-037 Test 3: length=0 -> done=1 one cycle after start, zero strobes.
REQ-038 Test 4: base=0x0000, length=3, byte_valid gapped 1-0-0-1-1 -> three strobes at 0x0000..0x0002, each data value presented exactly one cycle before its strobe.
REQ-039 Test 5: reset_n pulsed low after 2 of 5 bytes -> all outputs at reset values asynchronously and no later strobe; a new start then loads cleanly.
REQ-040 Test 6: start re-asserted during LOAD -> ignored, with the original base, length and checksum unaffected.
